piradip_cdc_word_sched: RTL

Source-domain scheduler that shares one four-phase CDC handshake channel (xpm_cdc_handshake-style `src_send`/`src_rcv`) between `N_REQ` requesters. Each requester posts a word, which is latched into a per-requester slot. Pending slots are served round-robin, and each word is tagged with its requester ID so the destination side can demultiplex. If a requester posts again before its slot is captured, the new word overwrites the old one (latest-value-wins), matching the codebase's auto-register CDC semantics.

---
 rtl/piradip_cdc_word_sched_pkg.sv | 15 +
 rtl/piradip_cdc_word_sched_if.sv | 21 ++
 rtl/piradip_cdc_word_sched_rr_arbiter.sv | 38 +++
 rtl/piradip_cdc_word_sched.sv | 115 +++++++++++
 4 files changed

// File: rtl/piradip_cdc_word_sched_pkg.sv
// piradip_cdc_word_sched shared types.
// FSM state enum and the requester ID width helper.
package piradip_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RELEASE
  } cdc_sched_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piradip_cdc_word_sched_if.sv
// Four-phase CDC handshake bundle (src_in/src_send/src_rcv).
// master: scheduler side; slave: CDC primitive side.
interface piradip_cdc_word_sched_if #(
  parameter int W = 34
);
  logic [W-1:0] hs_data;
  logic         hs_send;
  logic         hs_rcv;

  modport master (
    output hs_data,
    output hs_send,
    input  hs_rcv
  );

  modport slave (
    input  hs_data,
    input  hs_send,
    output hs_rcv
  );
endinterface

// File: rtl/piradip_cdc_word_sched_rr_arbiter.sv
// Combinational round-robin pick starting at ptr.
// Ports: req, ptr in; gnt_onehot, gnt_idx, any out.
module piradip_rr_arbiter
  import piradip_cdc_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW:0]   s;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    s          = '0;
    idx        = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(N))
        s = s - (IW+1)'(N);
      idx = IW'(s);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piradip_cdc_word_sched.sv
// Round-robin scheduler sharing one CDC handshake among N_REQ posters.
// Ports: clk, rst, req_data/valid in; req_pending/done, busy, coalesced out; hs (master).
module piradip_cdc_word_sched
  import piradip_cdc_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_pending,
  output logic [N_REQ-1:0]       req_done,
  piradip_cdc_word_sched_if.master hs,
  output logic                   busy,
  output logic [15:0]            coalesced
);

  localparam int ID_W = id_width(N_REQ);

  cdc_sched_state_t state_q, state_d;

  logic [WIDTH-1:0]      slot_q [N_REQ];
  logic [N_REQ-1:0]      pend_q;
  logic [ID_W-1:0]       ptr_q, g_q, gnt_idx;
  logic [N_REQ-1:0]      gnt_oh, cap_mask, ovr;
  logic                  any, cap, fin, send;
  logic [ID_W+WIDTH-1:0] hs_data_q;
  logic [16:0]           coal_sum;
  logic [15:0]           coal_d;

  piradip_rr_arbiter #(.N(N_REQ)) u_arb (
    .req        (pend_q),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_oh),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any && !hs.hs_rcv) state_d = SEND;
      SEND:    if (hs.hs_rcv)         state_d = RELEASE;
      RELEASE: if (!hs.hs_rcv)        state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // hs_send decodes the state register only, so it has no
  // combinational path from hs_rcv or the request inputs.
  always_comb begin
    cap  = 1'b0;
    fin  = 1'b0;
    send = 1'b0;
    busy = 1'b1;
    unique case (1'b1)
      state_q == IDLE: begin
        busy = 1'b0;
        cap  = any && !hs.hs_rcv;
      end
      state_q == SEND:    send = 1'b1;
      state_q == RELEASE: fin  = !hs.hs_rcv;
      default: ;
    endcase
  end

  // A post into the slot being captured is not an overwrite:
  // the old word is the one leaving.
  always_comb begin
    cap_mask = cap ? gnt_oh : '0;
    ovr      = req_valid & pend_q & ~cap_mask;
    coal_sum = {1'b0, coalesced};
    for (int i = 0; i < N_REQ; i++)
      coal_sum = coal_sum + 17'(ovr[i]);
    coal_d = coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      hs_data_q <= '0;
      g_q       <= '0;
      ptr_q     <= '0;
      req_done  <= '0;
      coalesced <= '0;
      for (int i = 0; i < N_REQ; i++)
        slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (req_valid[i])
          slot_q[i] <= req_data[i*WIDTH +: WIDTH];
      pend_q <= req_valid | (pend_q & ~cap_mask);
      if (cap) begin
        hs_data_q <= {gnt_idx, slot_q[gnt_idx]};
        g_q       <= gnt_idx;
      end
      req_done <= fin ? (N_REQ'(1) << g_q) : '0;
      if (fin)
        ptr_q <= (g_q == ID_W'(N_REQ-1)) ? '0 : g_q + 1'b1;
      coalesced <= coal_d;
    end
  end

  assign req_pending = pend_q;
  assign hs.hs_data  = hs_data_q;
  assign hs.hs_send  = send;

endmodule
